lii_out_arbiter: RTL and testbench
==================================

Name: lii_out_arbiter

Overview:
- Round-robin scheduler sharing one LII physical output channel (PW-bit, src/dst-tagged) among N kernel output streams.
- Grants one requester at a time for a bounded burst. Registers each accepted beat into a single-entry output stage. Stamps the LII src/dst sideband.
- Sits between the HLS kernel output streams and the LII phy output of a stream wrapper.

Parameters:
- N, 4, number of requesting streams (2..8).
- PW, 64, LII packing width.
- BURST, 16, maximum beats per grant (>=1).
- SRC_BASE, 0, LII src id of requester 0; requester i uses SRC_BASE+i (mod 256).

Ports:
- aclk  in  1  clock.
- arstn  in  1  synchronous active-low reset.
- req_tdata  in  N*PW  per-requester data, requester i at [i*PW +: PW].
- req_tvalid  in  N  per-requester valid.
- req_tready  out  N  per-requester ready.
- req_dst  in  N*8  per-requester LII destination id, requester i at [i*8 +: 8].
- lii_out_p0_tdata  out  PW  packed output data.
- lii_out_p0_tvalid  out  1  output valid.
- lii_out_p0_tready  in  1  output ready.
- lii_out_p0_src  out  8  source id of current beat.
- lii_out_p0_dst  out  8  destination id of current beat.
- grant_idx  out  3  index of the granted requester (valid when busy=1).
- busy  out  1  1 while in state GRANT.

Behaviour:
- Reset (arstn=0 at a rising edge):
  - State becomes IDLE.
  - lii_out_p0_tvalid=0; tdata, src and dst become 0.
  - Beat counter becomes 0.
  - Round-robin pointer last=N-1, so requester 0 has first priority.
  - grant_idx=0, busy=0, req_tready=0.
  - Reset mid-burst drops any held output beat. No partial state survives.
- The output stage is a single-entry register.
  - stage_free = !lii_out_p0_tvalid | lii_out_p0_tready.
  - On the edge where a beat is accepted, the register loads req_tdata[g], req_dst[g] and SRC_BASE+g, and tvalid is set to 1.
  - Otherwise, when lii_out_p0_tready=1, tvalid clears to 0.
  - Output data, src and dst are stable while tvalid=1 and tready=0.
- Latency: a beat accepted in cycle t is presented on lii_out in cycle t+1. At full throughput (tready held 1) the output sustains 1 beat/cycle.
- State IDLE:
  - All req_tready are 0.
  - If any req_tvalid is set, pick the first set bit searching from last+1 upward, wrapping modulo N.
  - Next edge: g<=winner, last<=winner, state GRANT, counter 0.
  - If no requester is valid, stay in IDLE.
- State GRANT:
  - req_tready[g] = stage_free. All other req_tready are 0.
  - Beat accepted = req_tvalid[g] & req_tready[g]. Each accepted beat increments the counter.
  - Release to IDLE on the edge where the accepted beat makes the count reach BURST.
  - Also release to IDLE on any edge where req_tvalid[g]=0 (requester gap), with no beat taken that cycle.
  - While tvalid[g]=1 and stage_free=0 (backpressure), hold the grant. Backpressure alone never releases.
- Each grant costs one IDLE arbitration cycle (bubble). Peak efficiency is BURST/(BURST+1).
- Fairness: a continuously valid requester waits at most (N-1)*(BURST+1) cycles with tready=1.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - The last beat of a burst being accepted while the output register drains in the same cycle is legal; both happen.
- A requester must hold tdata and dst stable while valid and not ready (AXI-Stream rule). The block does not check this.
- grant_idx and busy are registered state outputs, reflecting g and state==GRANT.
- No combinational path exists from lii_out_p0_tready to lii_out_p0_tvalid. The only combinational path from lii_out_p0_tready is to req_tready.

Test Plan:
- Single requester: N=4, BURST=4, only requester 2 valid with data 0x10..0x17, dst 0x05, tready=1.
  - Output: beats 0x10..0x13, then one bubble, then 0x14..0x17.
  - src=SRC_BASE+2, dst=0x05, grant_idx=2 throughout.
- Round-robin: all four requesters valid continuously, BURST=2.
  - Grant order 0,1,2,3,0,…
  - Every requester gets exactly 2 beats per round, with 1 bubble between grants.
- Backpressure: requester 1 granted, tready toggles 1,0,0,1.
  - Output data holds while tready=0.
  - req_tready[1] is 0 whenever tvalid=1 and tready=0.
  - No beat lost or duplicated. The grant is kept across the stall.
- Early release: requester 0 valid for 3 beats, then drops valid; requester 3 valid; BURST=16.
  - Grant released after beat 3.
  - Requester 3 granted after one IDLE cycle.
  - Output shows 3 beats with src=SRC_BASE, then beats with src=SRC_BASE+3.
- Reset mid-burst: assert arstn=0 with a beat held under tready=0.
  - Next edge: lii_out_p0_tvalid=0, busy=0.
  - After release of reset, requester 0 wins first arbitration.
- Wrap-around: last=3 (N=4), requesters 1 and 3 valid → requester 1 granted next, then 3.

Source files
------------

// File: rtl/lii_out_arbiter.sv
// lii_out_arbiter: round-robin share of one LII output channel among N
// kernel streams. One requester holds the grant for up to BURST beats;
// every accepted beat lands in a single-entry output register stamped
// with its LII src/dst ids. Each grant costs one IDLE arbitration cycle.
module lii_out_arbiter #(
   parameter int N        = 4,
   parameter int PW       = 64,
   parameter int BURST    = 16,
   parameter int SRC_BASE = 0
) (
   input  logic              aclk,
   input  logic              arstn,
   input  logic [N*PW-1:0]   req_tdata,
   input  logic [N-1:0]      req_tvalid,
   output logic [N-1:0]      req_tready,
   input  logic [N*8-1:0]    req_dst,
   output logic [PW-1:0]     lii_out_p0_tdata,
   output logic              lii_out_p0_tvalid,
   input  logic              lii_out_p0_tready,
   output logic [7:0]        lii_out_p0_src,
   output logic [7:0]        lii_out_p0_dst,
   output logic [2:0]        grant_idx,
   output logic              busy
);

   localparam int GW = $clog2(N);
   localparam int CW = $clog2(BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state_q;
   logic [GW-1:0]           g_q;
   logic [GW-1:0]           last_q;
   logic [CW-1:0]           cnt_q;
   logic [GW-1:0]           win;
   logic [GW-1:0]           idx_v;
   logic                    any_vld;
   logic [N-1:0][PW-1:0]    data_a;
   logic [N-1:0][7:0]       dst_a;
   logic                    stage_free;
   logic                    grant_vld;
   logic                    accept;
   logic                    last_beat;

   assign data_a     = req_tdata;
   assign dst_a      = req_dst;

   // The output register can take a beat when empty or draining this cycle;
   // this is the only place the downstream ready feeds combinationally.
   assign stage_free = !lii_out_p0_tvalid || lii_out_p0_tready;
   assign grant_vld  = req_tvalid[g_q];
   assign accept     = (state_q == GRANT) && grant_vld && stage_free;
   assign last_beat  = (cnt_q == CW'(BURST - 1));

   // Only the granted requester sees ready, and only while the stage is free.
   for (genvar i = 0; i < N; i++) begin : g_rdy
      assign req_tready[i] = (state_q == GRANT) && (g_q == GW'(i)) && stage_free;
   end

   // Round-robin pick: first valid requester searching upward from last+1.
   always_comb begin
      win     = '0;
      any_vld = 1'b0;
      idx_v   = '0;
      for (int i = 1; i <= N; i++) begin
         idx_v = GW'((int'(last_q) + i) % N);
         if (!any_vld && req_tvalid[idx_v]) begin
            any_vld = 1'b1;
            win     = idx_v;
         end
      end
   end

   // Grant FSM: arbitrate in IDLE, hold through backpressure, release on
   // burst limit or when the granted requester goes idle.
   always_ff @(posedge aclk) begin
      if (!arstn) begin
         state_q   <= IDLE;
         g_q       <= '0;
         last_q    <= GW'(N - 1);
         cnt_q     <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_vld) begin
                  state_q   <= GRANT;
                  g_q       <= win;
                  last_q    <= win;
                  cnt_q     <= '0;
                  grant_idx <= 3'(win);
                  busy      <= 1'b1;
               end
            end
            GRANT: begin
               if (!grant_vld) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else if (accept) begin
                  if (last_beat) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     busy    <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Single-entry output stage: load on accept, clear valid when drained.
   always_ff @(posedge aclk) begin
      if (!arstn) begin
         lii_out_p0_tvalid <= 1'b0;
         lii_out_p0_tdata  <= '0;
         lii_out_p0_src    <= '0;
         lii_out_p0_dst    <= '0;
      end else if (accept) begin
         lii_out_p0_tvalid <= 1'b1;
         lii_out_p0_tdata  <= data_a[g_q];
         lii_out_p0_dst    <= dst_a[g_q];
         lii_out_p0_src    <= 8'(SRC_BASE + int'(g_q));
      end else if (lii_out_p0_tready) begin
         lii_out_p0_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lii_out_arbiter.sv
// Directed bench for lii_out_arbiter (N=4, BURST=4, SRC_BASE=0x20).
// Requesters are fed from per-requester beat tables; every beat leaving
// the LII port is logged with its cycle so order, sideband and bubbles
// can be compared against hand-derived values.
module tb_lii_out_arbiter;

   localparam int N     = 4;
   localparam int PW    = 64;
   localparam int BURST = 4;
   localparam int SB    = 32;

   logic              aclk = 1'b0;
   logic              arstn = 1'b0;
   logic [N*PW-1:0]   req_tdata;
   logic [N-1:0]      req_tvalid;
   logic [N-1:0]      req_tready;
   logic [N*8-1:0]    req_dst;
   logic [PW-1:0]     lii_out_p0_tdata;
   logic              lii_out_p0_tvalid;
   logic              lii_out_p0_tready;
   logic [7:0]        lii_out_p0_src;
   logic [7:0]        lii_out_p0_dst;
   logic [2:0]        grant_idx;
   logic              busy;

   lii_out_arbiter #(.N(N), .PW(PW), .BURST(BURST), .SRC_BASE(SB)) dut (
      .aclk              (aclk),
      .arstn             (arstn),
      .req_tdata         (req_tdata),
      .req_tvalid        (req_tvalid),
      .req_tready        (req_tready),
      .req_dst           (req_dst),
      .lii_out_p0_tdata  (lii_out_p0_tdata),
      .lii_out_p0_tvalid (lii_out_p0_tvalid),
      .lii_out_p0_tready (lii_out_p0_tready),
      .lii_out_p0_src    (lii_out_p0_src),
      .lii_out_p0_dst    (lii_out_p0_dst),
      .grant_idx         (grant_idx),
      .busy              (busy)
   );

   always #5 aclk = ~aclk;

   // requester beat tables
   logic [63:0] sdata [4][32];
   logic [7:0]  sdst  [4];
   int          slen  [4];
   int          spos  [4];

   // output beat log
   logic [63:0] ob_data [64];
   logic [7:0]  ob_src  [64];
   logic [7:0]  ob_dst  [64];
   int          ob_cyc  [64];
   int          nb;

   int          cyc;
   logic [3:0]  hs;
   logic        bp_mode;
   logic [3:0]  rdy_pat;
   logic        rdy_fix;
   int          stall_cnt, bp_err, busy_cnt, busy_rise, gi_err, expect_g;
   logic        prev_stall, prev_busy;
   logic [63:0] prev_data;
   int          n_chk, n_pass;
   int          gap_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic apply();
      for (int r = 0; r < N; r++) begin
         req_tvalid[r]          = (spos[r] < slen[r]);
         req_tdata[r*PW +: PW]  = sdata[r][spos[r] & 31];
         req_dst[r*8 +: 8]      = sdst[r];
      end
      lii_out_p0_tready = bp_mode ? rdy_pat[2'(cyc % 4)] : rdy_fix;
   endtask

   // One clock: observe at the falling edge, advance stimulus after rise.
   task automatic step();
      @(negedge aclk);
      hs = req_tvalid & req_tready;
      if (lii_out_p0_tvalid && lii_out_p0_tready && nb < 64) begin
         ob_data[nb] = lii_out_p0_tdata;
         ob_src[nb]  = lii_out_p0_src;
         ob_dst[nb]  = lii_out_p0_dst;
         ob_cyc[nb]  = cyc;
         nb++;
      end
      if (prev_stall && (!lii_out_p0_tvalid || lii_out_p0_tdata != prev_data)) bp_err++;
      prev_stall = lii_out_p0_tvalid && !lii_out_p0_tready;
      prev_data  = lii_out_p0_tdata;
      if (prev_stall) begin
         stall_cnt++;
         if (req_tready != '0) bp_err++;
      end
      if (busy) begin
         busy_cnt++;
         if (expect_g >= 0 && int'(grant_idx) != expect_g) gi_err++;
      end
      if (busy && !prev_busy) busy_rise++;
      prev_busy = busy;
      @(posedge aclk);
      #1;
      cyc++;
      for (int r = 0; r < N; r++) if (hs[r]) spos[r]++;
      apply();
   endtask

   task automatic clear_log();
      nb = 0; stall_cnt = 0; bp_err = 0; busy_cnt = 0; busy_rise = 0;
      gi_err = 0; expect_g = -1; prev_stall = 1'b0; prev_busy = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ob_data[i] = '0; ob_src[i] = '0; ob_dst[i] = '0; ob_cyc[i] = 0;
      end
   endtask

   task automatic clear_q();
      for (int r = 0; r < N; r++) begin
         slen[r] = 0; spos[r] = 0; sdst[r] = '0;
      end
   endtask

   task automatic load(input int r, input int len, input logic [63:0] base, input logic [7:0] d);
      slen[r] = len; spos[r] = 0; sdst[r] = d;
      for (int k = 0; k < len; k++) sdata[r][k] = base + 64'(k);
   endtask

   // Hold reset across one edge, check the cleared outputs, then release.
   task automatic do_reset();
      arstn = 1'b0;
      step();
      chk("rst_tvalid", lii_out_p0_tvalid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_tready", req_tready, 4'b0);
      arstn = 1'b1;
      clear_log();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      bp_mode = 1'b0; rdy_pat = 4'b1001; rdy_fix = 1'b1;
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 32; k++) sdata[r][k] = '0;
      clear_q();
      clear_log();
      apply();

      // reset state
      do_reset();
      chk("rst_tdata", lii_out_p0_tdata, 64'h0);
      chk("rst_src", lii_out_p0_src, 8'h0);
      chk("rst_dst", lii_out_p0_dst, 8'h0);
      chk("rst_grant_idx", grant_idx, 3'd0);

      // single requester 2, bursts of 4 with one bubble between
      clear_q(); load(2, 8, 64'h10, 8'h05); expect_g = 2; apply();
      run(20);
      chk("t1_nbeats", nb, 8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t1_data%0d", k), ob_data[k], 64'h10 + 64'(k));
         chk($sformatf("t1_src%0d", k), ob_src[k], 8'h22);
         chk($sformatf("t1_dst%0d", k), ob_dst[k], 8'h05);
      end
      chk("t1_gap_burst0", ob_cyc[3] - ob_cyc[0], 3);
      chk("t1_bubble", ob_cyc[4] - ob_cyc[3], 2);
      chk("t1_gap_burst1", ob_cyc[7] - ob_cyc[4], 3);
      chk("t1_grant_idx_err", gi_err, 0);
      chk("t1_busy_cycles", busy_cnt, 8);

      // round robin, all four valid: groups of 4 in order 0,1,2,3,0,1,2,3
      do_reset(); clear_q();
      for (int r = 0; r < N; r++) load(r, 8, 64'hA000 + 64'(r * 256), 8'h40 + 8'(r));
      apply();
      run(50);
      chk("t2_nbeats", nb, 32);
      gap_err = 0;
      for (int j = 0; j < 32; j++) begin
         chk($sformatf("t2_src%0d", j), ob_src[j], 8'h20 + 8'((j / 4) % 4));
         chk($sformatf("t2_data%0d", j), ob_data[j],
             64'hA000 + 64'(((j / 4) % 4) * 256 + (j / 16) * 4 + (j % 4)));
         if (j > 0 && (ob_cyc[j] - ob_cyc[j-1]) != ((j % 4 == 0) ? 2 : 1)) gap_err++;
      end
      chk("t2_dst_r3", ob_dst[12], 8'h43);
      chk("t2_bubble_pattern", gap_err, 0);

      // backpressure on requester 1 with tready 1,0,0,1
      do_reset(); clear_q(); load(1, 4, 64'hB0, 8'h11); expect_g = 1;
      bp_mode = 1'b1; apply();
      run(30);
      bp_mode = 1'b0; rdy_fix = 1'b1; apply();
      chk("t3_nbeats", nb, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t3_data%0d", k), ob_data[k], 64'hB0 + 64'(k));
      chk("t3_stall_seen", stall_cnt > 0, 1'b1);
      chk("t3_hold_err", bp_err, 0);
      chk("t3_grants", busy_rise, 1);
      chk("t3_grant_idx_err", gi_err, 0);

      // early release: requester 0 has 3 beats, then requester 3
      do_reset(); clear_q(); load(0, 3, 64'hC0, 8'h01); load(3, 4, 64'hD0, 8'h02); apply();
      run(20);
      chk("t4_nbeats", nb, 7);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("t4_src%0d", k), ob_src[k], (k < 3) ? 8'h20 : 8'h23);
         chk($sformatf("t4_data%0d", k), ob_data[k], (k < 3) ? 64'hC0 + 64'(k) : 64'hD0 + 64'(k - 3));
      end
      chk("t4_switch_gap", ob_cyc[3] - ob_cyc[2], 3);

      // reset while a beat is held under backpressure
      do_reset(); clear_q(); load(1, 4, 64'hE0, 8'h07); rdy_fix = 1'b0; apply();
      run(4);
      chk("t5_pre_tvalid", lii_out_p0_tvalid, 1'b1);
      chk("t5_pre_busy", busy, 1'b1);
      do_reset();
      clear_q(); load(0, 2, 64'hF0, 8'h03); load(2, 2, 64'hF8, 8'h04);
      rdy_fix = 1'b1; apply();
      run(15);
      chk("t5_nbeats", nb, 4);
      chk("t5_first_src", ob_src[0], 8'h20);
      chk("t5_first_data", ob_data[0], 64'hF0);
      chk("t5_third_src", ob_src[2], 8'h22);

      // wrap-around from last=3: requesters 1 and 3 valid
      do_reset(); clear_q(); load(1, 2, 64'h61, 8'h09); load(3, 2, 64'h63, 8'h0A); apply();
      run(15);
      chk("t6_nbeats", nb, 4);
      chk("t6_src0", ob_src[0], 8'h21);
      chk("t6_src1", ob_src[1], 8'h21);
      chk("t6_src2", ob_src[2], 8'h23);
      chk("t6_src3", ob_src[3], 8'h23);
      chk("t6_data2", ob_data[2], 64'h63);
      chk("t6_dst2", ob_dst[2], 8'h0A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
